systolic_os_array: RTL and testbench
====================================

Name: systolic_os_array

Overview:
Parametrised output-stationary systolic MAC array computing C = A·B for an ARRAY_SIZE×ARRAY_SIZE tile over a runtime reduction length k_len.
- Successor to the fixed 32×32, 8-bit array.
- Adds: internal input skewing, valid/ready input streaming with bubbles, signed/unsigned mode, saturating accumulation with sticky overflow, optional accumulate-across-runs, and a handshaked row-by-row result drain.
- Sits between the SRAM fetch controller (A columns, B rows) and the quantise/write-back stage.

Parameters:
ARRAY_SIZE, 32, N: rows and columns of PEs.
DATA_WIDTH, 8, operand width.
ACC_WIDTH, 21, accumulator and output element width; must be >= 2*DATA_WIDTH.
KLEN_W, 9, width of k_len.

Ports:
clk  in  1  clock.
srstn  in  1  synchronous active-low reset.
start  in  1  run request; sampled in IDLE only.
k_len  in  KLEN_W  reduction length; latched on accepted start.
acc_clr  in  1  latched on start; 1 = zero accumulators, 0 = keep previous results.
is_signed  in  1  latched on start; 1 = two's-complement operands.
in_valid  in  1  a_vec/b_vec valid.
in_ready  out  1  array accepting vectors.
a_vec  in  N*DATA_WIDTH  column k of A; element i (row i) at [i*DATA_WIDTH +: DATA_WIDTH].
b_vec  in  N*DATA_WIDTH  row k of B; element j (column j) at [j*DATA_WIDTH +: DATA_WIDTH].
out_valid  out  1  result row valid.
out_ready  in  1  downstream accepts row.
out_row  out  $clog2(N)  index of presented row.
out_data  out  N*ACC_WIDTH  C[out_row][j] at [j*ACC_WIDTH +: ACC_WIDTH].
busy  out  1  not IDLE.
done  out  1  one-cycle pulse after last row accepted.
ovf  out  1  sticky saturation flag for current run.

Behaviour:
- Reset (srstn=0 at posedge), including mid-run: FSM→IDLE; all accumulators, skew and pipeline registers, counters and ovf cleared. in_ready=0, out_valid=0, out_row=0, busy=0, done=0, out_data=0.
- FSM states IDLE, LOAD, FLUSH, DRAIN:
  - IDLE: on start, latch k_len/acc_clr/is_signed. If acc_clr=1, zero all accumulators. Clear ovf. Go to LOAD, or to FLUSH if k_len=0.
  - LOAD: in_ready=1. Each in_valid&in_ready beat injects a_vec/b_vec into the skew stage and increments kcnt. A cycle without in_valid injects zeros (a bubble, contributing 0). When kcnt reaches k_len on a beat, go to FLUSH; in_ready drops the following cycle.
  - FLUSH: injects zeros for exactly 2*N-1 cycles (2N-2 skew/propagation + 1 MAC register), then DRAIN with out_row=0.
  - DRAIN: out_valid=1; out_data is the registered accumulator row out_row. On out_valid&out_ready, out_row increments. If out_row=N-1, go to IDLE with done=1 for one cycle. out_data and out_row are held stable while out_ready=0.
- Start in any state other than IDLE is ignored. start and done may coincide: done is pulsed and start is taken on the next IDLE cycle only.
- Skew: row i's A element is delayed i cycles; column j's B element is delayed j cycles. PE(i,j) forwards a to PE(i,j+1) and b to PE(i+1,j), one register per hop.
- Arithmetic:
  - Signed mode: the product is a signed 2*DATA_WIDTH value, sign-extended to ACC_WIDTH.
  - Unsigned mode: operands and product are zero-extended, and the accumulator is treated as unsigned.
  - Each accumulate saturates to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1] signed, or [0, 2^ACC_WIDTH−1] unsigned. Any saturation sets ovf until the next accepted start.
- Accumulators update only in LOAD/FLUSH. They are frozen in IDLE/DRAIN and retained across runs when acc_clr=0.

Decomposition:
- Package systolic_pkg: state enum (IDLE, LOAD, FLUSH, DRAIN); localparam FLUSH_CYC = 2*ARRAY_SIZE-1; functions sat_add_s and sat_add_u (ACC_WIDTH-generic).
- Sub-module systolic_pe: one PE, with a/b forwarding registers, multiplier, saturating accumulator, clear, enable, mode input and overflow output. The top level contains skew registers, FSM, counters, the drain mux and the ovf OR-reduce.

Test Plan:
1. N=4, signed, acc_clr=1, k_len=4, A=identity, B rows {1,2,3,4},{5,6,7,8},{-1,-2,-3,-4},{9,10,11,12} → out rows equal B rows in order 0..3; done once; ovf=0.
2. N=4, signed, k_len=3, all a=−128, b=−128 → every element 49152. Same run unsigned with 255/255 → every element 195075.
3. N=4, ACC_WIDTH=21, signed, k_len=64, a=b=−128 (sum 1048576) → all elements 1048575, ovf=1. Next run acc_clr=1, k_len=1, a=b=1 → all 1, ovf=0.
4. Test-1 stimulus with in_valid low on beats 1 and 3 (bubbles), and out_ready low 3 cycles at out_row=2 → identical results; out_data/out_row stable during stall; no row skipped or duplicated.
5. Test-2 signed run repeated with acc_clr=0 → every element 98304.
6. srstn=0 for one cycle mid-LOAD (kcnt=2) → next cycle busy=0, in_ready=0, out_valid=0. Fresh test-1 run then produces correct results; k_len=0 run with acc_clr=1 drains all-zero rows.

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM states, flush length and saturating adders for the
// output-stationary systolic array.
package systolic_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    localparam int DEF_ARRAY_SIZE = 32;
    localparam int FLUSH_CYC      = 2*DEF_ARRAY_SIZE-1;
    localparam int MAX_W          = 64;

    function automatic int flush_cycles(input int n);
        return 2*n-1;
    endfunction

    // Operands arrive sign-extended to MAX_W; result is {overflow, clamped sum}.
    function automatic logic [MAX_W:0] sat_add_s(input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b,
                                                input int unsigned w);
        logic signed [MAX_W:0] s, hi, lo;
        s  = $signed({a[MAX_W-1], a}) + $signed({b[MAX_W-1], b});
        hi = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo = -hi - 65'sd1;
        if (s > hi) return {1'b1, hi[MAX_W-1:0]};
        if (s < lo) return {1'b1, lo[MAX_W-1:0]};
        return {1'b0, s[MAX_W-1:0]};
    endfunction

    function automatic logic [MAX_W:0] sat_add_u(input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b,
                                                input int unsigned w);
        logic [MAX_W:0] s, hi;
        s  = {1'b0, a} + {1'b0, b};
        hi = ({{MAX_W{1'b0}}, 1'b1} << w) - {{MAX_W{1'b0}}, 1'b1};
        return (s > hi) ? {1'b1, hi[MAX_W-1:0]} : {1'b0, s[MAX_W-1:0]};
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// systolic_pe: one MAC cell; forwards a right and b down, accumulates a*b with
// saturation in signed or unsigned mode and keeps a sticky overflow bit.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 21
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  i_en,
    input  logic                  i_clr,
    input  logic                  i_ovf_clr,
    input  logic                  i_signed,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_a,
    output logic [DATA_WIDTH-1:0] o_b,
    output logic [ACC_WIDTH-1:0]  o_acc,
    output logic                  o_ovf
);

    localparam int PW = 2*DATA_WIDTH;

    logic [DATA_WIDTH-1:0] r_a, r_b;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic                  r_ovf;
    logic [PW-1:0]         w_prod_s, w_prod_u;
    logic [MAX_W-1:0]      w_acc_x, w_prod_x;
    logic [MAX_W:0]        w_sum;
    logic                  w_unused;

    assign w_prod_s = $signed({{DATA_WIDTH{i_a[DATA_WIDTH-1]}}, i_a}) *
                      $signed({{DATA_WIDTH{i_b[DATA_WIDTH-1]}}, i_b});
    assign w_prod_u = {{DATA_WIDTH{1'b0}}, i_a} * {{DATA_WIDTH{1'b0}}, i_b};
    assign w_acc_x  = i_signed ? {{(MAX_W-ACC_WIDTH){r_acc[ACC_WIDTH-1]}}, r_acc}
                               : {{(MAX_W-ACC_WIDTH){1'b0}}, r_acc};
    assign w_prod_x = i_signed ? {{(MAX_W-PW){w_prod_s[PW-1]}}, w_prod_s}
                               : {{(MAX_W-PW){1'b0}}, w_prod_u};
    assign w_sum    = i_signed ? sat_add_s(w_acc_x, w_prod_x, ACC_WIDTH)
                               : sat_add_u(w_acc_x, w_prod_x, ACC_WIDTH);
    assign w_unused = ^w_sum[MAX_W-1:ACC_WIDTH];

    always_ff @(posedge clk) begin
        if (!srstn) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_a <= i_a;
            r_b <= i_b;
            if (i_clr) r_acc <= '0;
            else if (i_en) r_acc <= w_sum[ACC_WIDTH-1:0];
            if (i_ovf_clr) r_ovf <= 1'b0;
            else if (i_en && w_sum[MAX_W]) r_ovf <= 1'b1;
        end
    end

    assign o_a   = r_a;
    assign o_b   = r_b;
    assign o_acc = r_acc;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/systolic_os_array.sv
// systolic_os_array: output-stationary NxN MAC array with input skewing,
// valid/ready streaming, flush sequencing and a handshaked row drain.
module systolic_os_array
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE = 32,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 21,
    parameter int KLEN_W     = 9
) (
    input  logic                             clk,
    input  logic                             srstn,
    input  logic                             start,
    input  logic [KLEN_W-1:0]                k_len,
    input  logic                             acc_clr,
    input  logic                             is_signed,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] a_vec,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] b_vec,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(ARRAY_SIZE)-1:0]    out_row,
    output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  out_data,
    output logic                             busy,
    output logic                             done,
    output logic                             ovf
);

    localparam int N       = ARRAY_SIZE;
    localparam int DW      = DATA_WIDTH;
    localparam int AW      = ACC_WIDTH;
    localparam int RW      = $clog2(N);
    localparam int FLUSH_N = flush_cycles(N);
    localparam int FW      = $clog2(FLUSH_N+1);

    state_t            r_state, w_next;
    logic [KLEN_W-1:0] r_klen, r_kcnt, w_kcnt_nxt;
    logic [FW-1:0]     r_fcnt;
    logic [RW-1:0]     r_row;
    logic              r_signed, r_done;
    logic              w_beat, w_clr, w_ovf_clr, w_en, w_last_row, w_start;
    logic [DW-1:0]     w_a_inj [N];
    logic [DW-1:0]     w_b_inj [N];
    logic [DW-1:0]     w_a [N][N+1];
    logic [DW-1:0]     w_b [N+1][N];
    logic [AW-1:0]     w_acc [N][N];
    logic [N*N-1:0]    w_ovf;
    logic [N-1:0]      w_unused_a, w_unused_b;

    assign w_kcnt_nxt = r_kcnt + KLEN_W'(1);
    assign w_last_row = r_row == RW'(N-1);
    assign w_en       = (r_state == LOAD) || (r_state == FLUSH);

    always_ff @(posedge clk) begin
        if (!srstn) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_clr     = 1'b0;
        w_ovf_clr = 1'b0;
        w_beat    = 1'b0;
        case (r_state)
            IDLE: begin
                w_start   = start;
                w_clr     = start && acc_clr;
                w_ovf_clr = start;
                if (start) w_next = (k_len == '0) ? FLUSH : LOAD;
            end
            LOAD: begin
                w_beat = in_valid;
                if (in_valid && w_kcnt_nxt == r_klen) w_next = FLUSH;
            end
            FLUSH: if (r_fcnt == FW'(FLUSH_N-1)) w_next = DRAIN;
            DRAIN: if (out_ready && w_last_row) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            r_klen   <= '0;
            r_kcnt   <= '0;
            r_fcnt   <= '0;
            r_row    <= '0;
            r_signed <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            if (w_start) begin
                r_klen   <= k_len;
                r_signed <= is_signed;
                r_kcnt   <= '0;
                r_fcnt   <= '0;
            end
            if (w_beat) r_kcnt <= w_kcnt_nxt;
            if (r_state == FLUSH) r_fcnt <= r_fcnt + FW'(1);
            if (r_state == DRAIN && out_ready) r_row <= w_last_row ? '0 : r_row + RW'(1);
            r_done <= (r_state == DRAIN) && out_ready && w_last_row;
        end
    end

    // Row i of A and column i of B are delayed i cycles so operands of equal k
    // meet at PE(i,j) exactly i+j cycles after injection.
    for (genvar i = 0; i < N; i++) begin : g_skew
        assign w_a_inj[i] = w_beat ? a_vec[i*DW +: DW] : '0;
        assign w_b_inj[i] = w_beat ? b_vec[i*DW +: DW] : '0;
        if (i == 0) begin : g_direct
            assign w_a[0][0] = w_a_inj[0];
            assign w_b[0][0] = w_b_inj[0];
        end else begin : g_delay
            logic [DW-1:0] r_a_d [i];
            logic [DW-1:0] r_b_d [i];
            always_ff @(posedge clk) begin
                if (!srstn) begin
                    for (int s = 0; s < i; s++) begin
                        r_a_d[s] <= '0;
                        r_b_d[s] <= '0;
                    end
                end else begin
                    r_a_d[0] <= w_a_inj[i];
                    r_b_d[0] <= w_b_inj[i];
                    for (int s = 1; s < i; s++) begin
                        r_a_d[s] <= r_a_d[s-1];
                        r_b_d[s] <= r_b_d[s-1];
                    end
                end
            end
            assign w_a[i][0] = r_a_d[i-1];
            assign w_b[0][i] = r_b_d[i-1];
        end
        assign w_unused_a[i] = ^w_a[i][N];
        assign w_unused_b[i] = ^w_b[N][i];
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            systolic_pe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) u_pe (
                .clk       (clk),
                .srstn     (srstn),
                .i_en      (w_en),
                .i_clr     (w_clr),
                .i_ovf_clr (w_ovf_clr),
                .i_signed  (r_signed),
                .i_a       (w_a[i][j]),
                .i_b       (w_b[i][j]),
                .o_a       (w_a[i][j+1]),
                .o_b       (w_b[i+1][j]),
                .o_acc     (w_acc[i][j]),
                .o_ovf     (w_ovf[i*N+j])
            );
        end
    end

    always_comb begin
        out_data = '0;
        for (int j = 0; j < N; j++) out_data[j*AW +: AW] = w_acc[r_row][j];
    end

    assign in_ready  = r_state == LOAD;
    assign out_valid = r_state == DRAIN;
    assign out_row   = r_row;
    assign busy      = r_state != IDLE;
    assign done      = r_done;
    assign ovf       = |w_ovf;

endmodule

// File: tb/tb_systolic_os_array.sv
// tb_systolic_os_array: directed runs on a 4x4 array with hand-computed results,
// covering bubbles, drain stalls, saturation, accumulate-across-runs and reset.
module tb_systolic_os_array;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 21;
    localparam int KW = 9;

    logic            clk = 1'b0, srstn = 1'b0, start = 1'b0, acc_clr = 1'b0;
    logic            is_signed = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [KW-1:0]   k_len = '0;
    logic [N*DW-1:0] a_vec = '0, b_vec = '0;
    logic            in_ready, out_valid, busy, done, ovf;
    logic [1:0]      out_row;
    logic [N*AW-1:0] out_data;

    int            n_tests = 0, n_fail = 0, n_done = 0;
    logic [DW-1:0] am [64][N];
    logic [DW-1:0] bm [64][N];
    logic [AW-1:0] exp_c [N][N];
    int            b1 [N][N] = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}, '{-1, -2, -3, -4}, '{9, 10, 11, 12}};

    systolic_os_array #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .KLEN_W(KW)) dut (
        .clk(clk), .srstn(srstn), .start(start), .k_len(k_len), .acc_clr(acc_clr),
        .is_signed(is_signed), .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec),
        .b_vec(b_vec), .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_data(out_data), .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (done) n_done++;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_t1();
        for (int k = 0; k < N; k++)
            for (int i = 0; i < N; i++) begin
                am[k][i]    = (i == k) ? 8'd1 : 8'd0;
                bm[k][i]    = DW'(b1[k][i]);
                exp_c[k][i] = AW'(b1[k][i]);
            end
    endtask

    task automatic load_const(input int a, input int b, input int nb, input int e);
        for (int k = 0; k < nb; k++)
            for (int i = 0; i < N; i++) begin
                am[k][i] = DW'(a);
                bm[k][i] = DW'(b);
            end
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++) exp_c[r][j] = AW'(e);
    endtask

    task automatic run_start(input int kl, input logic clr, input logic sgn);
        start = 1'b1; k_len = KW'(kl); acc_clr = clr; is_signed = sgn;
        @(negedge clk);
        start = 1'b0; acc_clr = 1'b0; is_signed = 1'b0;
    endtask

    task automatic feed(input int nb, input logic [63:0] bubbles);
        int k = 0, slot = 0;
        while (k < nb && slot < 200) begin
            if (slot < 64 && bubbles[slot]) begin
                in_valid = 1'b0; a_vec = '1; b_vec = '1;
            end else begin
                in_valid = 1'b1;
                for (int i = 0; i < N; i++) begin
                    a_vec[i*DW +: DW] = am[k][i];
                    b_vec[i*DW +: DW] = bm[k][i];
                end
                k++;
            end
            @(negedge clk);
            slot++;
        end
        in_valid = 1'b0; a_vec = '0; b_vec = '0;
    endtask

    task automatic drain(input string tag, input int stall_row, input logic exp_ovf);
        int c = 0;
        logic [N*AW-1:0] er;
        while (!out_valid && c < 200) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_valid"}, out_valid, 1);
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < N; j++) er[j*AW +: AW] = exp_c[r][j];
            check($sformatf("%s_row%0d", tag, r), out_row, r);
            for (int j = 0; j < N; j++)
                check($sformatf("%s_c%0d%0d", tag, r, j), out_data[j*AW +: AW], exp_c[r][j]);
            if (r == stall_row) begin
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check($sformatf("%s_stall_row", tag), out_row, r);
                    check($sformatf("%s_stall_data", tag), out_data, er);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ovf"}, ovf, exp_ovf);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_row", out_row, 0);
        check("rst_out_data", out_data, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        srstn = 1'b1;
        @(negedge clk);

        load_t1();
        run_start(4, 1, 1);
        feed(4, 64'd0);
        check("t1_in_ready_drop", in_ready, 0);
        drain("t1", -1, 0);

        load_const(-128, -128, 3, 49152);
        run_start(3, 1, 1);
        feed(3, 64'd0);
        drain("t2s", -1, 0);

        load_const(-128, -128, 3, 98304);
        run_start(3, 0, 1);
        feed(3, 64'd0);
        drain("t5", -1, 0);

        load_const(255, 255, 3, 195075);
        run_start(3, 1, 0);
        feed(3, 64'd0);
        drain("t2u", -1, 0);

        load_const(-128, -128, 64, 1048575);
        run_start(64, 1, 1);
        feed(64, 64'd0);
        drain("t3sat", -1, 1);

        load_const(1, 1, 1, 1);
        run_start(1, 1, 1);
        feed(1, 64'd0);
        drain("t3one", -1, 0);

        load_t1();
        run_start(4, 1, 1);
        feed(4, 64'b1010);
        drain("t4", 2, 0);

        load_t1();
        run_start(4, 1, 1);
        feed(2, 64'd0);
        srstn = 1'b0;
        @(negedge clk);
        check("t6_busy", busy, 0);
        check("t6_in_ready", in_ready, 0);
        check("t6_out_valid", out_valid, 0);
        check("t6_out_data", out_data, 0);
        srstn = 1'b1;
        @(negedge clk);
        run_start(4, 1, 1);
        feed(4, 64'd0);
        drain("t6", -1, 0);

        load_const(0, 0, 0, 0);
        run_start(0, 1, 1);
        drain("t6k0", -1, 0);

        check("done_count", n_done, 9);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
